// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS data-memory responder.
//   state_t    : 2-bit responder FSM encoding (IDLE / WAIT / RESP)
//   WORD_BYTES : bytes per memory word
//   DATA_W     : data path width
//   ADDR_W     : byte address width
//   addr_bad() : misalignment / out-of-range decode for a byte address
package mips_pkg;

  localparam int WORD_BYTES = 4;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when the address is not word aligned or lies beyond the
  // 2^mem_size word array (any bit above the word index set).
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a,
                                    input int unsigned mem_size);
    logic [ADDR_W-1:0] hi;
    hi = a >> (mem_size + 32'd2);
    return (a[1:0] != 2'd0) || (hi != {ADDR_W{1'b0}});
  endfunction

endpackage

// File: rtl/d_mem_array.sv
// Word storage for the data-memory responder.
//   clock : write clock
//   we    : write enable, commits wdata to mem[waddr] at the rising edge
//   waddr : word index for the write
//   wdata : word to store
//   raddr : word index for the combinational read
//   rdata : mem[raddr]
// Contents are deliberately not reset.
module d_mem_array
  import mips_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**AW];

  // Synchronous word write.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/d_mem_responder.sv
// Data-memory responder for the MIPS load/store port with programmable
// wait states.
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset
//   Address   : byte address of the access
//   WriteData : store data
//   MemRead   : load request
//   MemWrite  : store request
//   ReadData  : load data, non-zero only in the Ready cycle of a good load
//   Ready     : one-cycle completion pulse
//   AddrError : one-cycle pulse with Ready when the request was rejected
// A request accepted at edge N sits in WAIT/RESP for WAIT_CYCLES+1 edges;
// Ready, AddrError and ReadData are registered off the RESP state, so they
// show in the cycle after edge N+WAIT_CYCLES+1, with the FSM back in IDLE.
module d_mem_responder
  import mips_pkg::*;
#(
  parameter int MemSize     = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [DATA_W-1:0] ReadData,
  output logic              Ready,
  output logic              AddrError
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [MemSize-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 is_write_q, is_write_d;
  logic                 err_q, err_d;
  logic                 ready_q, ready_d;
  logic                 aerr_q, aerr_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;

  logic [DATA_W-1:0]    mem_rdata;
  logic                 mem_we;

  // Store commits at the edge that ends RESP; rejected requests never write.
  assign mem_we = (state_q == RESP) && is_write_q && !err_q;

  d_mem_array #(
    .AW (MemSize)
  ) u_array (
    .clock (clock),
    .we    (mem_we),
    .waddr (idx_q),
    .wdata (wdata_q),
    .raddr (idx_q),
    .rdata (mem_rdata)
  );

  // Next-state, request latch and response computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    err_d      = err_q;
    ready_d    = 1'b0;
    aerr_d     = 1'b0;
    rdata_d    = {DATA_W{1'b0}};
    case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          idx_d      = Address[MemSize+1:2];
          wdata_d    = WriteData;
          is_write_d = MemWrite;
          err_d      = addr_bad(Address, MemSize) || (MemRead && MemWrite);
          cnt_d      = WAIT_LD;
          state_d    = (WAIT_LD == 4'd0) ? RESP : WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // A zero count cannot occur here; treat it like the last wait state.
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
        aerr_d  = err_q;
        if (!is_write_q && !err_q) begin
          rdata_d = mem_rdata;
        end else begin
          rdata_d = {DATA_W{1'b0}};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any pending request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= {MemSize{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      aerr_q     <= 1'b0;
      rdata_q    <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      aerr_q     <= aerr_d;
      rdata_q    <= rdata_d;
    end
  end

  assign Ready     = ready_q;
  assign AddrError = aerr_q;
  assign ReadData  = rdata_q;

endmodule

// File: tb/tb_d_mem_responder.sv
// Directed bench for d_mem_responder: a vector table of single accesses on a
// WAIT_CYCLES=2 instance plus hand sequences for reset and back-to-back
// behaviour on a WAIT_CYCLES=0 instance.
module tb_d_mem_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        mrd, mwr, rdy, aerr;

  logic [31:0] addr0, wdata0, rdata0;
  logic        mrd0, mwr0, rdy0, aerr0;

  int n_tests = 0;
  int n_fail  = 0;

  d_mem_responder #(.MemSize(10), .WAIT_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .Address(addr), .WriteData(wdata),
    .MemRead(mrd), .MemWrite(mwr), .ReadData(rdata), .Ready(rdy),
    .AddrError(aerr)
  );

  d_mem_responder #(.MemSize(10), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .Address(addr0), .WriteData(wdata0),
    .MemRead(mrd0), .MemWrite(mwr0), .ReadData(rdata0), .Ready(rdy0),
    .AddrError(aerr0)
  );

  typedef struct {
    string       name;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, bit r, bit w, logic [31:0] a,
                              logic [31:0] d, logic [31:0] e, bit er);
    vec_t v;
    v.name = n; v.rd = r; v.wr = w; v.addr = a; v.wdata = d;
    v.exp_rd = e; v.exp_err = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // One access on the WAIT_CYCLES=2 instance; lat counts edges after the
  // accepting edge until Ready is seen (-1 on timeout).
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble,
                        output logic [31:0] got_rd, output logic got_err,
                        output int lat, output logic clean_after);
    int k;
    @(negedge clock);
    addr = a; wdata = d; mrd = rd; mwr = wr;
    @(posedge clock);
    k = 0;
    @(negedge clock);
    while (!rdy && k < 20) begin
      if (scramble) begin
        addr  = a ^ 32'h0000_0004;
        wdata = ~d;
      end
      @(posedge clock);
      k++;
      @(negedge clock);
    end
    lat     = rdy ? k : -1;
    got_rd  = rdata;
    got_err = aerr;
    mrd = 1'b0; mwr = 1'b0;
    @(negedge clock);
    clean_after = !rdy && !aerr && (rdata == 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input bit scramble);
    logic [31:0] got_rd;
    logic        got_err, clean;
    int          lat;
    access(v.rd, v.wr, v.addr, v.wdata, scramble, got_rd, got_err, lat, clean);
    check({v.name, " latency"}, 32'(lat), 32'd3);
    check({v.name, " rdata"}, got_rd, v.exp_rd);
    check({v.name, " aerr"}, {31'd0, got_err}, {31'd0, v.exp_err});
    check({v.name, " one-cycle"}, {31'd0, clean}, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    addr = 32'h0; wdata = 32'h0; mrd = 1'b0; mwr = 1'b0;
    addr0 = 32'h0; wdata0 = 32'h0; mrd0 = 1'b0; mwr0 = 1'b0;

    vecs.push_back(mk("w10_old",  0, 1, 32'h0000_0010, 32'h0BAD_F00D, 32'h0, 0));
    vecs.push_back(mk("w40",      0, 1, 32'h0000_0040, 32'h1234_5678, 32'h0, 0));
    vecs.push_back(mk("r40",      1, 0, 32'h0000_0040, 32'h0, 32'h1234_5678, 0));
    vecs.push_back(mk("r42_mis",  1, 0, 32'h0000_0042, 32'h0, 32'h0, 1));
    vecs.push_back(mk("r1000_oor",1, 0, 32'h0000_1000, 32'h0, 32'h0, 1));
    vecs.push_back(mk("r40_again",1, 0, 32'h0000_0040, 32'h0, 32'h1234_5678, 0));
    vecs.push_back(mk("w8",       0, 1, 32'h0000_0008, 32'hA5A5_A5A5, 32'h0, 0));
    vecs.push_back(mk("rw8_both", 1, 1, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0, 1));
    vecs.push_back(mk("r8",       1, 0, 32'h0000_0008, 32'h0, 32'hA5A5_A5A5, 0));
    vecs.push_back(mk("w0",       0, 1, 32'h0000_0000, 32'h1111_1111, 32'h0, 0));
    vecs.push_back(mk("w1000_oor",0, 1, 32'h0000_1000, 32'h9999_9999, 32'h0, 1));
    vecs.push_back(mk("w3_mis",   0, 1, 32'h0000_0003, 32'h7777_7777, 32'h0, 1));
    vecs.push_back(mk("r0",       1, 0, 32'h0000_0000, 32'h0, 32'h1111_1111, 0));
    vecs.push_back(mk("wffc_top", 0, 1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0, 0));
    vecs.push_back(mk("rffc_top", 1, 0, 32'h0000_0FFC, 32'h0, 32'hCAFE_F00D, 0));
    vecs.push_back(mk("r_hi_oor", 1, 0, 32'h8000_0000, 32'h0, 32'h0, 1));
    vecs.push_back(mk("w24",      0, 1, 32'h0000_0024, 32'h2424_2424, 32'h0, 0));

    // Reset state.
    repeat (3) @(negedge clock);
    check("reset ready", {31'd0, rdy}, 32'd0);
    check("reset aerr", {31'd0, aerr}, 32'd0);
    check("reset rdata", rdata, 32'h0);
    reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], 1'b0);

    // Inputs changed during WAIT are ignored.
    run_vec(mk("w20_scr", 0, 1, 32'h0000_0020, 32'h5555_AAAA, 32'h0, 0), 1'b1);
    run_vec(mk("r20_latched", 1, 0, 32'h0000_0020, 32'h0, 32'h5555_AAAA, 0), 1'b0);
    run_vec(mk("r24_untouched", 1, 0, 32'h0000_0024, 32'h0, 32'h2424_2424, 0), 1'b0);

    // Reset mid-WAIT of a store: outputs low, store never commits.
    @(negedge clock);
    addr = 32'h0000_0010; wdata = 32'hDEAD_BEEF; mwr = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    mwr = 1'b0;
    #1;
    check("rst_wait ready", {31'd0, rdy}, 32'd0);
    check("rst_wait aerr", {31'd0, aerr}, 32'd0);
    check("rst_wait rdata", rdata, 32'h0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    run_vec(mk("r10_after_rst", 1, 0, 32'h0000_0010, 32'h0, 32'h0BAD_F00D, 0), 1'b0);

    // Reset asserted during the Ready cycle clears outputs immediately.
    @(negedge clock);
    addr = 32'h0000_0040; mrd = 1'b1;
    @(posedge clock);
    repeat (3) @(posedge clock);
    @(negedge clock);
    mrd = 1'b0;
    check("pre_rst ready", {31'd0, rdy}, 32'd1);
    check("pre_rst rdata", rdata, 32'h1234_5678);
    reset = 1'b0;
    #1;
    check("rst_resp ready", {31'd0, rdy}, 32'd0);
    check("rst_resp rdata", rdata, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // WAIT_CYCLES=0 with the request held: Ready on alternate cycles.
    @(negedge clock);
    addr0 = 32'h0000_0004; mrd0 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock);
      @(negedge clock);
      check($sformatf("w0_pattern[%0d]", k), {31'd0, rdy0}, {31'd0, k[0]});
    end
    mrd0 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
